// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/DIV unit holding the HI/LO register pair
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, next;
    logic [CW-1:0]      cnt;
    logic               op_q, sgn_res, sgn_rem, dbz;
    logic [2*WIDTH-1:0] acc, mul_step, div_step, prod;
    logic [WIDTH-1:0]   mcand, mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     madd, rem_sh, diff;
    logic               sa, sb;

    assign sa    = ~ifunsigned & A[WIDTH-1];
    assign sb    = ~ifunsigned & B[WIDTH-1];
    assign mag_a = sa ? -A : A;
    assign mag_b = sb ? -B : B;

    assign busy        = (state == RUN) || (state == FIX);
    assign done        = state == DONE;
    assign div_by_zero = done & dbz;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // next-state: divide by zero skips straight to DONE without ever going busy
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = start ? ((op && B == '0) ? DONE : RUN) : IDLE;
            RUN:     next = (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            FIX:     next = DONE;
            default: next = IDLE;
        endcase
    end

    // one iteration of shift-add multiply / restoring divide, plus final sign fix
    always_comb begin
        madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_step = {madd, acc[WIDTH-1:1]};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mcand};
        div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod     = sgn_res ? -acc : acc;
        quo      = sgn_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = sgn_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // datapath: acc holds {partial product, multiplier} or {remainder, quotient}
    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            op_q    <= 1'b0;
            sgn_res <= 1'b0;
            sgn_rem <= 1'b0;
            dbz     <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_q    <= op;
                        sgn_res <= sa ^ sb;
                        sgn_rem <= sa;
                        dbz     <= op && B == '0;
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, op ? mag_a : mag_b};
                        mcand   <= op ? mag_b : mag_a;
                    end
                end
                RUN: begin
                    acc <= op_q ? div_step : mul_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: {hi, lo} <= op_q ? {rem, quo} : prod;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed checks of HI/LO multiply/divide unit
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        rst, start, op, ifunsigned, hi_we, lo_we;
    logic [31:0] A, B, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          errors = 0;
    int          lat, bc;
    logic        dz;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .ifunsigned(ifunsigned),
        .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue a request, then count edges after the accepting edge until done
    task automatic do_op(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bcount, output logic dzero);
        start = 1'b1; op = o; ifunsigned = u; A = a; B = b;
        step();
        start = 1'b0;
        l = 0;
        bcount = 0;
        while (!done && l < 100) begin
            bcount += int'(busy);
            step();
            l++;
        end
        dzero = div_by_zero;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; ifunsigned = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; A = '0; B = '0; wdata = '0;
        step();
        step();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        step();

        do_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz);
        chk("multu_lat", lat, 33);
        chk("multu_busy_cycles", bc, 33);
        chk("multu_busy_at_done", busy, 0);
        chk("multu_dbz", dz, 0);
        chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        step();
        chk("multu_done_once", done, 0);

        do_op(1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, lat, bc, dz);
        chk("mult_neg_lat", lat, 33);
        chk("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        step();

        do_op(1'b0, 1'b0, 32'h80000000, 32'h80000000, lat, bc, dz);
        chk("mult_min_hilo", {hi, lo}, 64'h40000000_00000000);
        step();

        do_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, lat, bc, dz);
        chk("div_neg_lat", lat, 33);
        chk("div_neg_dbz", dz, 0);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        step();

        do_op(1'b1, 1'b1, 32'd100, 32'd7, lat, bc, dz);
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        step();

        do_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz);
        chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
        step();

        hi_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        step();
        lo_we = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
        do_op(1'b1, 1'b0, 32'd5, 32'd0, lat, bc, dz);
        chk("dbz_lat", lat, 0);
        chk("dbz_pulse", dz, 1);
        chk("dbz_busy_cycles", bc, 0);
        chk("dbz_busy", busy, 0);
        step();
        chk("dbz_done_once", {done, div_by_zero}, 0);
        chk("dbz_hilo_kept", {hi, lo}, {32'h1234, 32'h5678});

        start = 1'b1; op = 1'b0; ifunsigned = 1'b1; A = 32'd3; B = 32'd4;
        step();
        start = 1'b0;
        repeat (9) step();
        start = 1'b1; op = 1'b1; A = 32'd9; B = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
        step();
        start = 1'b0; hi_we = 1'b0;
        chk("busy_mthi_ignored", hi, 32'h1234);
        chk("busy_still", busy, 1);
        lat = 10;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        chk("ignored_start_lat", lat, 33);
        chk("ignored_start_hilo", {hi, lo}, {32'd0, 32'd12});
        step();

        start = 1'b1; op = 1'b0; ifunsigned = 1'b1; A = 32'd5; B = 32'd5;
        step();
        start = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_hilo", {hi, lo}, 0);
        bc = 0;
        repeat (40) begin
            bc += int'(done) + int'(busy);
            step();
        end
        chk("midrst_no_done", bc, 0);
        do_op(1'b0, 1'b1, 32'd2, 32'd3, lat, bc, dz);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_hilo", {hi, lo}, {32'd0, 32'd6});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
